// File: rtl/ram_fifo_ctrl.sv
// FIFO controller in front of a single-port RAM with one registered read port.
// Reads win the port over writes; one read outstanding; registered output stage.
module ram_fifo_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH+1:0] count,
  output logic                  full,
  output logic                  empty,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout
);

  localparam logic [0:0]            ST_IDLE    = 1'b0;
  localparam logic [0:0]            ST_RD_WAIT = 1'b1;
  localparam logic [ADDR_WIDTH:0]   DEPTH      = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0]   MEM_ZERO   = {(ADDR_WIDTH+1){1'b0}};
  localparam logic [ADDR_WIDTH:0]   MEM_ONE    = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] PTR_ZERO   = {ADDR_WIDTH{1'b0}};
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE    = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [DATA_WIDTH-1:0] DATA_ZERO  = {DATA_WIDTH{1'b0}};
  localparam logic [ADDR_WIDTH:0]   CNT_PAD    = {(ADDR_WIDTH+1){1'b0}};

  logic [0:0]            r_state;
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_mem_count;
  logic                  r_out_valid;
  logic [DATA_WIDTH-1:0] r_out_data;

  logic w_rd_wait;
  logic w_rd_issue;
  logic w_wr_accept;

  assign w_rd_wait   = (r_state == ST_RD_WAIT);
  assign w_rd_issue  = (r_mem_count != MEM_ZERO) && (r_state == ST_IDLE) &&
                       (!r_out_valid || out_ready);
  assign in_ready    = (r_mem_count != DEPTH) && !w_rd_issue;
  assign w_wr_accept = in_valid && in_ready;

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign count     = {1'b0, r_mem_count} + {CNT_PAD, w_rd_wait} + {CNT_PAD, r_out_valid};
  assign full      = (r_mem_count == DEPTH);
  assign empty     = (count == {1'b0, CNT_PAD});

  // RAM port steering: a read issue owns the address, otherwise it parks on wr_ptr
  always_comb begin
    ram_we   = 1'b0;
    ram_addr = r_wr_ptr;
    ram_din  = in_data;
    if (w_rd_issue) begin
      ram_addr = r_rd_ptr;
    end else if (w_wr_accept) begin
      ram_we = 1'b1;
    end else begin
      ram_we = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_wr_ptr    <= PTR_ZERO;
      r_rd_ptr    <= PTR_ZERO;
      r_mem_count <= MEM_ZERO;
    end else begin
      case (r_state)
        ST_IDLE:    r_state <= w_rd_issue ? ST_RD_WAIT : ST_IDLE;
        ST_RD_WAIT: r_state <= ST_IDLE;
        default:    r_state <= ST_IDLE;
      endcase
      if (w_rd_issue) begin
        r_rd_ptr    <= r_rd_ptr + PTR_ONE;
        r_mem_count <= r_mem_count - MEM_ONE;
      end else if (w_wr_accept) begin
        r_wr_ptr    <= r_wr_ptr + PTR_ONE;
        r_mem_count <= r_mem_count + MEM_ONE;
      end else begin
        r_mem_count <= r_mem_count;
      end
    end
  end

  // Output stage: a reload from RD_WAIT takes precedence over a pop
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= DATA_ZERO;
    end else if (w_rd_wait) begin
      r_out_valid <= 1'b1;
      r_out_data  <= ram_dout;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= r_out_valid;
    end
  end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Directed bench for ram_fifo_ctrl with a behavioural single-port RAM attached.
module tb_ram_fifo_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [5:0] count;
  logic       full;
  logic       empty;
  logic       ram_we;
  logic [3:0] ram_addr;
  logic [7:0] ram_din;
  logic [7:0] ram_dout;
  logic [7:0] mem [0:15];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Registered-read single-port RAM
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  ram_fifo_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count), .full(full), .empty(empty),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = 8'h00;
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_vec++; if (count !== 6'd0 || empty !== 1'b1 || full !== 1'b0) begin n_err++;
      $display("FAIL reset_status: count=%0d empty=%b full=%b, want 0/1/0", count, empty, full); end
    n_vec++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 8'h00) begin n_err++;
      $display("FAIL reset_out: in_ready=%b out_valid=%b out_data=%h, want 1/0/00", in_ready, out_valid, out_data); end
    // traffic so the output register holds a nonzero word before reset
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = 8'h30 + 8'(i);
      next_cycle();
    end
    n_vec++; if (out_valid !== 1'b1 || out_data !== 8'h30) begin n_err++;
      $display("FAIL reset_pre: out_valid=%b out_data=%h, want 1/30", out_valid, out_data); end
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    next_cycle();
    next_cycle();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    #1;
    n_vec++; if (count !== 6'd0 || empty !== 1'b1 || out_valid !== 1'b0 || in_ready !== 1'b1 || ram_we !== 1'b0) begin n_err++;
      $display("FAIL reset_mid: count=%0d empty=%b out_valid=%b in_ready=%b ram_we=%b, want 0/1/0/1/0",
               count, empty, out_valid, in_ready, ram_we); end
    n_vec++; if (out_data !== 8'h00 || full !== 1'b0) begin n_err++;
      $display("FAIL reset_mid_data: out_data=%h full=%b, want 00/0", out_data, full); end
  endtask

  task automatic test_single();
    do_reset();
    in_valid = 1'b1; in_data = 8'hAA; out_ready = 1'b1;
    #1;
    n_vec++; if (in_ready !== 1'b1 || ram_we !== 1'b1 || ram_addr !== 4'd0 || ram_din !== 8'hAA) begin n_err++;
      $display("FAIL single_c0: in_ready=%b we=%b addr=%0d din=%h, want 1/1/0/AA", in_ready, ram_we, ram_addr, ram_din); end
    next_cycle();
    in_valid = 1'b0;
    #1;
    n_vec++; if (ram_we !== 1'b0 || ram_addr !== 4'd0 || in_ready !== 1'b0 || count !== 6'd1) begin n_err++;
      $display("FAIL single_c1: we=%b addr=%0d in_ready=%b count=%0d, want 0/0/0/1", ram_we, ram_addr, in_ready, count); end
    next_cycle();
    n_vec++; if (out_valid !== 1'b0 || count !== 6'd1) begin n_err++;
      $display("FAIL single_c2: out_valid=%b count=%0d, want 0/1", out_valid, count); end
    next_cycle();
    n_vec++; if (out_valid !== 1'b1 || out_data !== 8'hAA || count !== 6'd1) begin n_err++;
      $display("FAIL single_c3: out_valid=%b out_data=%h count=%0d, want 1/AA/1", out_valid, out_data, count); end
    next_cycle();
    n_vec++; if (empty !== 1'b1 || out_valid !== 1'b0 || count !== 6'd0) begin n_err++;
      $display("FAIL single_c4: empty=%b out_valid=%b count=%0d, want 1/0/0", empty, out_valid, count); end
  endtask

  task automatic test_fill();
    int accepted = 0;
    int popped = 0;
    int last_pop = -10;
    do_reset();
    for (int c = 0; c < 40; c++) begin
      in_valid = 1'b1; in_data = 8'(accepted);
      #1;
      if (in_ready) accepted++;
      next_cycle();
    end
    in_valid = 1'b0;
    #1;
    n_vec++; if (accepted !== 17) begin n_err++;
      $display("FAIL fill_accepts: got %0d, want 17", accepted); end
    n_vec++; if (count !== 6'd17 || full !== 1'b1 || in_ready !== 1'b0) begin n_err++;
      $display("FAIL fill_status: count=%0d full=%b in_ready=%b, want 17/1/0", count, full, in_ready); end
    n_vec++; if (out_valid !== 1'b1 || out_data !== 8'h00) begin n_err++;
      $display("FAIL fill_head: out_valid=%b out_data=%h, want 1/00", out_valid, out_data); end
    out_ready = 1'b1;
    for (int c = 0; c < 80 && popped < 17; c++) begin
      #1;
      if (out_valid) begin
        n_vec++; if (out_data !== 8'(popped)) begin n_err++;
          $display("FAIL drain_data: got %h, want %h", out_data, 8'(popped)); end
        n_vec++; if (c - last_pop < 2) begin n_err++;
          $display("FAIL drain_rate: pop gap %0d cycles, want >= 2", c - last_pop); end
        last_pop = c;
        popped++;
      end
      next_cycle();
    end
    #1;
    n_vec++; if (popped !== 17 || empty !== 1'b1) begin n_err++;
      $display("FAIL drain_total: popped=%0d empty=%b, want 17/1", popped, empty); end
    out_ready = 1'b0;
  endtask

  task automatic test_priority();
    logic [7:0] exp_d;
    do_reset();
    in_valid = 1'b1; out_ready = 1'b1;
    // steady state alternates write / read-issue from the first cycle
    for (int k = 0; k < 14; k++) begin
      in_data = 8'h20 + 8'(k / 2);
      #1;
      n_vec++; if (in_ready !== ((k % 2) == 0) || ram_we !== ((k % 2) == 0)) begin n_err++;
        $display("FAIL prio_ready k=%0d: in_ready=%b we=%b, want %b", k, in_ready, ram_we, (k % 2) == 0); end
      n_vec++; if (ram_addr !== 4'((k % 2 == 0) ? k / 2 : (k - 1) / 2)) begin n_err++;
        $display("FAIL prio_addr k=%0d: got %0d", k, ram_addr); end
      if (k >= 3) begin
        exp_d = 8'h20 + 8'((k - 3) / 2);
        n_vec++; if (out_valid !== (k % 2 == 1) || ((k % 2 == 1) && out_data !== exp_d)) begin n_err++;
          $display("FAIL prio_out k=%0d: out_valid=%b out_data=%h, want %b/%h", k, out_valid, out_data, k % 2 == 1, exp_d); end
      end
      next_cycle();
    end
    in_valid = 1'b0;
  endtask

  task automatic test_wrap();
    int sent = 0;
    int recv = 0;
    logic [7:0] exp_d;
    do_reset();
    for (int c = 0; c < 2000 && recv < 40; c++) begin
      in_valid  = (sent < 40) && ($urandom % 4 != 0);
      in_data   = 8'h55 + 8'(sent);
      out_ready = ($urandom % 3 != 0);
      #1;
      if (in_valid && in_ready) begin
        n_vec++; if (ram_we !== 1'b1 || ram_addr !== 4'(sent % 16)) begin n_err++;
          $display("FAIL wrap_waddr: we=%b addr=%0d, want 1/%0d", ram_we, ram_addr, sent % 16); end
        sent++;
      end
      if (out_valid && out_ready) begin
        exp_d = 8'h55 + 8'(recv);
        n_vec++; if (out_data !== exp_d) begin n_err++;
          $display("FAIL wrap_data #%0d: got %h, want %h", recv, out_data, exp_d); end
        recv++;
      end
      next_cycle();
    end
    in_valid = 1'b0; out_ready = 1'b0;
    #1;
    n_vec++; if (recv !== 40 || empty !== 1'b1) begin n_err++;
      $display("FAIL wrap_total: recv=%0d empty=%b, want 40/1", recv, empty); end
  endtask

  task automatic test_reset_mid_read();
    int seen = 0;
    do_reset();
    in_valid = 1'b1; in_data = 8'h77;
    next_cycle();
    in_valid = 1'b0;
    next_cycle();
    #1;
    n_vec++; if (count !== 6'd1 || out_valid !== 1'b0) begin n_err++;
      $display("FAIL rmr_pre: count=%0d out_valid=%b, want 1/0", count, out_valid); end
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_vec++; if (out_valid !== 1'b0 || count !== 6'd0) begin n_err++;
        $display("FAIL rmr_post c=%0d: out_valid=%b count=%0d, want 0/0", c, out_valid, count); end
      next_cycle();
    end
    in_valid = 1'b1; in_data = 8'h99; out_ready = 1'b1;
    next_cycle();
    in_valid = 1'b0;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (out_valid) begin
        seen++;
        n_vec++; if (out_data !== 8'h99) begin n_err++;
          $display("FAIL rmr_data: got %h, want 99", out_data); end
      end
      next_cycle();
    end
    n_vec++; if (seen !== 1 || empty !== 1'b1) begin n_err++;
      $display("FAIL rmr_alone: words=%0d empty=%b, want 1/1", seen, empty); end
    out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = 8'h00;
    for (int i = 0; i < 16; i++) mem[i] = 8'hEE;
    next_cycle();
    test_reset();
    test_single();
    test_fill();
    test_priority();
    test_wrap();
    test_reset_mid_read();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ram_fifo_ctrl.md
Name: ram_fifo_ctrl

Overview:
FIFO controller that sits directly in front of single_port_ram and owns its we/addr/din port and its dout.
- Accepts a valid/ready write stream from the home-automation event path.
- Buffers words in the RAM and presents them in order on a valid/ready output stream.
- Arbitrates the RAM's single port: at most one access per cycle, reads have priority.

Parameters:
DATA_WIDTH, 8, word width; must match the attached RAM.
ADDR_WIDTH, 4, RAM address width; DEPTH = 2**ADDR_WIDTH entries.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
in_valid  input  1  write word offered
in_ready  output  1  write word accepted this cycle when in_valid is also high
in_data  input  DATA_WIDTH  write word
out_valid  output  1  out_data holds the oldest word
out_ready  input  1  consumer takes out_data this cycle when out_valid is also high
out_data  output  DATA_WIDTH  oldest word, registered
count  output  ADDR_WIDTH+2  total words held (RAM + in-flight read + output register)
full  output  1  RAM region holds DEPTH words
empty  output  1  count == 0
ram_we  output  1  to RAM we
ram_addr  output  ADDR_WIDTH  to RAM addr
ram_din  output  DATA_WIDTH  to RAM din
ram_dout  input  DATA_WIDTH  from RAM dout; 1-cycle registered read latency

Behaviour:
- Reset (rst=1 at clk edge):
  - wr_ptr=0, rd_ptr=0, mem_count=0, state=IDLE, out_valid=0, out_data=0.
  - Outputs: in_ready=1, count=0, full=0, empty=1.
  - RAM contents are not cleared.
  - A read in flight is discarded.
  - rst overrides all other inputs in the same cycle.
- States:
  - IDLE: no read outstanding.
  - RD_WAIT: a read was issued last cycle; ram_dout is valid this cycle.
- Read issue:
  - rd_issue = (mem_count != 0) && (state == IDLE) && (!out_valid || out_ready).
  - On rd_issue: ram_addr=rd_ptr, ram_we=0; rd_ptr+1 and mem_count-1 at the edge; next state RD_WAIT.
- RD_WAIT:
  - out_data <= ram_dout and out_valid <= 1 at the edge ending this cycle; next state IDLE.
  - The RAM port is free for a write in this cycle.
- Write:
  - in_ready = (mem_count != DEPTH) && !rd_issue. A read always beats a write.
  - Accepted write: ram_we=1, ram_addr=wr_ptr, ram_din=in_data; wr_ptr+1 and mem_count+1 at the edge.
  - When no write occurs, ram_addr=wr_ptr and ram_we=0.
- Output register:
  - out_valid && out_ready clears out_valid at the edge, unless reloaded in the same cycle from RD_WAIT.
  - out_data holds its value while out_valid=1 && out_ready=0.
- Pointers:
  - ADDR_WIDTH bits with natural wrap from DEPTH-1 to 0.
  - mem_count is ADDR_WIDTH+1 bits, range 0..DEPTH.
- Status: count = mem_count + (state==RD_WAIT) + out_valid. full = (mem_count==DEPTH). All status outputs are combinational from registers.
- Latency: a write accepted in cycle 0 into an empty controller gives read issue in cycle 1 (RD_WAIT in cycle 2) and out_valid=1 in cycle 3.
- Throughput: output limited to 1 word per 2 cycles (single port, one read outstanding).
- Capacity: maximum occupancy with out_ready held low is DEPTH+1 (RAM full plus the output register).
- Simultaneous events:
  - A read and a write in the same cycle cannot occur.
  - A RAM read in RD_WAIT while a write targets the same address is irrelevant, because dout was sampled from the previous edge.
  - Word order is strictly FIFO.

Test Plan:
- Reset: assert rst 2 cycles mid-traffic -> next cycle count=0, empty=1, out_valid=0, in_ready=1, ram_we=0.
- Single word: push 8'hAA at cycle 0, out_ready=1 -> ram_we=1 at addr 0 in cycle 0; read at addr 0 in cycle 1; out_valid=1 with out_data=8'hAA in cycle 3; empty=1 after the pop.
- Fill: out_ready=0, push 8'h00..8'h11 continuously -> in_ready drops after 17 accepts; count=17, full=1; out_data=8'h00. Then drain with out_ready=1 -> 8'h00..8'h10 in order, one word per 2 cycles at most.
- Read priority: out_ready=1 with in_valid held high -> in_ready=0 exactly in each cycle where a read issues; no word lost or duplicated.
- Wrap-around: stream 40 words (8'h55+i) with pseudo-random in_valid and out_ready -> outputs equal inputs in order; pointers wrap past address 15 with no gap.
- Reset mid-read: rst in the cycle where the state is RD_WAIT -> out_valid remains 0 and count=0; the next push of 8'h99 emerges alone.
